// File: rtl/l2tlb_l1resp_if.sv
// l2tlb_l1resp_if: request/ack/snoop/sack channel bundle between the L1 TLB
// (master) and the L2 TLB responder (slave), plus the responder's sticky
// sack error flag.
interface l2tlb_l1resp_if;

  typedef struct packed {
    logic [3:0]  txid;
    logic [31:0] laddr;
  } I_l1tlbtol2tlb_req_type;

  typedef struct packed {
    logic [3:0]  txid;
    logic [10:0] hpaddr;
    logic [2:0]  ppaddr;
    logic [2:0]  fault;
  } I_l2tlbtol1tlb_ack_type;

  typedef struct packed {
    logic [10:0] hpaddr;
  } I_l2tlbtol1tlb_snoop_type;

  typedef struct packed {
    logic [10:0] hpaddr;
  } I_l1tlbtol2tlb_sack_type;

  logic                     l1tlbtol2tlb_req_valid;
  logic                     l1tlbtol2tlb_req_retry;
  I_l1tlbtol2tlb_req_type   l1tlbtol2tlb_req;

  logic                     l2tlbtol1tlb_ack_valid;
  logic                     l2tlbtol1tlb_ack_retry;
  I_l2tlbtol1tlb_ack_type   l2tlbtol1tlb_ack;

  logic                     l2tlbtol1tlb_snoop_valid;
  logic                     l2tlbtol1tlb_snoop_retry;
  I_l2tlbtol1tlb_snoop_type l2tlbtol1tlb_snoop;

  logic                     l1tlbtol2tlb_sack_valid;
  logic                     l1tlbtol2tlb_sack_retry;
  I_l1tlbtol2tlb_sack_type  l1tlbtol2tlb_sack;

  logic                     sack_err;

  // L2 TLB responder side
  modport slave (
    input  l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req,
    output l1tlbtol2tlb_req_retry,
    output l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack,
    input  l2tlbtol1tlb_ack_retry,
    output l2tlbtol1tlb_snoop_valid, l2tlbtol1tlb_snoop,
    input  l2tlbtol1tlb_snoop_retry,
    input  l1tlbtol2tlb_sack_valid, l1tlbtol2tlb_sack,
    output l1tlbtol2tlb_sack_retry,
    output sack_err
  );

  // L1 TLB requester side
  modport master (
    output l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req,
    input  l1tlbtol2tlb_req_retry,
    input  l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack,
    output l2tlbtol1tlb_ack_retry,
    input  l2tlbtol1tlb_snoop_valid, l2tlbtol1tlb_snoop,
    output l2tlbtol1tlb_snoop_retry,
    output l1tlbtol2tlb_sack_valid, l1tlbtol2tlb_sack,
    input  l1tlbtol2tlb_sack_retry,
    input  sack_err
  );

endinterface

// File: rtl/l2tlb_l1resp.sv
// l2tlb_l1resp: identity-translating stand-in for the L2 TLB. Answers L1 TLB
// misses, tracks the hpaddrs the L1 holds, and snoops a victim out of the L1
// before reusing its table slot.
// Optional feature macro: L2TLB_RESP_SNOOP_EN. When undefined, a full-table
// miss silently overwrites the victim and no snoop is ever issued.
module l2tlb_l1resp #(
  parameter int Entries = 8
) (
  input  logic          clk,
  input  logic          reset,
  l2tlb_l1resp_if.slave bus
);

  localparam int IdxW = $clog2(Entries);

  typedef enum logic [2:0] {IDLE, LOOKUP, SNOOP, WAIT_SACK, ACK} state_e;

  state_e            state_q, state_d;
  logic [3:0]        txid_q, txid_d;
  logic [10:0]       hpaddr_q, hpaddr_d;
  logic [10:0]       victim_q, victim_d;
  logic [IdxW-1:0]   vptr_q, vptr_d;
  logic [Entries-1:0] valid_q, valid_d;
  logic [10:0]       tag_q [Entries];
  logic [10:0]       tag_d [Entries];

  logic req_retry_q, req_retry_d;
  logic ack_valid_q, ack_valid_d;
  logic snoop_valid_q, snoop_valid_d;
  logic sack_retry_q, sack_retry_d;
  logic sack_err_q, sack_err_d;

  logic            hit;
  logic            free_found;
  logic [IdxW-1:0] free_idx;
  logic            req_fire, ack_fire, snoop_fire, sack_fire, sack_match;

  assign req_fire   = bus.l1tlbtol2tlb_req_valid && !req_retry_q;
  assign ack_fire   = ack_valid_q && !bus.l2tlbtol1tlb_ack_retry;
  assign snoop_fire = snoop_valid_q && !bus.l2tlbtol1tlb_snoop_retry;
  assign sack_fire  = bus.l1tlbtol2tlb_sack_valid && !sack_retry_q;
  // WAIT_SACK is unreachable without the snoop feature, so every sack is an error there
  assign sack_match = (state_q == WAIT_SACK) && sack_fire &&
                      (bus.l1tlbtol2tlb_sack.hpaddr == victim_q);

  // Table search: hit on any valid matching tag, and lowest-index free slot
  always_comb begin
    hit        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = Entries - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == hpaddr_q)) hit = 1'b1;
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  // Next-state logic: FSM transitions, table updates and sack error tracking
  always_comb begin
    state_d    = state_q;
    txid_d     = txid_q;
    hpaddr_d   = hpaddr_q;
    victim_d   = victim_q;
    vptr_d     = vptr_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    sack_err_d = sack_err_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          txid_d   = bus.l1tlbtol2tlb_req.txid;
          hpaddr_d = bus.l1tlbtol2tlb_req.laddr[22:12];
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          state_d = ACK;
        end else if (free_found) begin
          valid_d[free_idx] = 1'b1;
          tag_d[free_idx]   = hpaddr_q;
          state_d           = ACK;
        end else begin
`ifdef L2TLB_RESP_SNOOP_EN
          victim_d = tag_q[vptr_q];
          state_d  = SNOOP;
`else
          tag_d[vptr_q] = hpaddr_q;
          vptr_d        = vptr_q + IdxW'(1);
          state_d       = ACK;
`endif
        end
      end
      SNOOP: begin
        if (snoop_fire) state_d = WAIT_SACK;
      end
      WAIT_SACK: begin
        if (sack_match) begin
          tag_d[vptr_q] = hpaddr_q;
          vptr_d        = vptr_q + IdxW'(1);
          state_d       = ACK;
        end
      end
      ACK: begin
        if (ack_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sack_fire && !sack_match) sack_err_d = 1'b1;
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    req_retry_d  = (state_d != IDLE);
    ack_valid_d  = (state_d == ACK);
`ifdef L2TLB_RESP_SNOOP_EN
    snoop_valid_d = (state_d == SNOOP);
`else
    snoop_valid_d = 1'b0;
`endif
    sack_retry_d = 1'b0;
  end

  // State, request context and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      txid_q        <= '0;
      hpaddr_q      <= '0;
      victim_q      <= '0;
      vptr_q        <= '0;
      req_retry_q   <= 1'b0;
      ack_valid_q   <= 1'b0;
      snoop_valid_q <= 1'b0;
      sack_retry_q  <= 1'b0;
      sack_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      txid_q        <= txid_d;
      hpaddr_q      <= hpaddr_d;
      victim_q      <= victim_d;
      vptr_q        <= vptr_d;
      req_retry_q   <= req_retry_d;
      ack_valid_q   <= ack_valid_d;
      snoop_valid_q <= snoop_valid_d;
      sack_retry_q  <= sack_retry_d;
      sack_err_q    <= sack_err_d;
    end
  end

  // Tracking table; reset forgets everything the L1 may hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < Entries; i++) tag_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < Entries; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign bus.l1tlbtol2tlb_req_retry   = req_retry_q;
  assign bus.l2tlbtol1tlb_ack_valid   = ack_valid_q;
  assign bus.l2tlbtol1tlb_ack         = {txid_q, hpaddr_q, hpaddr_q[2:0], 3'b000};
  assign bus.l2tlbtol1tlb_snoop_valid = snoop_valid_q;
  assign bus.l2tlbtol1tlb_snoop       = victim_q;
  assign bus.l1tlbtol2tlb_sack_retry  = sack_retry_q;
  assign bus.sack_err                 = sack_err_q;

endmodule

// File: tb/tb_l2tlb_l1resp.sv
// tb_l2tlb_l1resp: directed self-checking bench for l2tlb_l1resp.
// Covers the snoop path when L2TLB_RESP_SNOOP_EN is defined, otherwise the
// silent-replacement path.
module tb_l2tlb_l1resp;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  l2tlb_l1resp_if bus ();

  l2tlb_l1resp #(.Entries(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rst_vals();
    chk("rst_ack_valid",   32'(bus.l2tlbtol1tlb_ack_valid), 0);
    chk("rst_snoop_valid", 32'(bus.l2tlbtol1tlb_snoop_valid), 0);
    chk("rst_req_retry",   32'(bus.l1tlbtol2tlb_req_retry), 0);
    chk("rst_sack_retry",  32'(bus.l1tlbtol2tlb_sack_retry), 0);
    chk("rst_sack_err",    32'(bus.sack_err), 0);
    chk("rst_ack_payload", 32'(bus.l2tlbtol1tlb_ack), 0);
    chk("rst_snoop_hp",    32'(bus.l2tlbtol1tlb_snoop.hpaddr), 0);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs checked before any clock edge
  task automatic async_reset_check();
    #2 reset = 1'b1;
    #1 rst_vals();
    #1 reset = 1'b0;
  endtask

  // Request transfer in cycle N; returns in cycle N+1
  task automatic send_req(input logic [3:0] tx, input logic [31:0] la);
    bus.l1tlbtol2tlb_req.txid  = tx;
    bus.l1tlbtol2tlb_req.laddr = la;
    bus.l1tlbtol2tlb_req_valid = 1'b1;
    chk("req_retry_idle", 32'(bus.l1tlbtol2tlb_req_retry), 0);
    tick();
    bus.l1tlbtol2tlb_req_valid = 1'b0;
    chk("req_retry_busy", 32'(bus.l1tlbtol2tlb_req_retry), 1);
    chk("ack_early",      32'(bus.l2tlbtol1tlb_ack_valid), 0);
  endtask

  // Called in the first ack cycle; optionally stalls the ack for 'stall' cycles
  task automatic expect_ack(input logic [3:0] tx, input logic [10:0] hp, input int stall);
    $display("ack txid=%0d hpaddr=0x%03h stall=%0d", tx, hp, stall);
    chk("ack_valid",     32'(bus.l2tlbtol1tlb_ack_valid), 1);
    chk("ack_txid",      32'(bus.l2tlbtol1tlb_ack.txid), 32'(tx));
    chk("ack_hpaddr",    32'(bus.l2tlbtol1tlb_ack.hpaddr), 32'(hp));
    chk("ack_ppaddr",    32'(bus.l2tlbtol1tlb_ack.ppaddr), 32'(hp[2:0]));
    chk("ack_fault",     32'(bus.l2tlbtol1tlb_ack.fault), 0);
    chk("req_retry_ack", 32'(bus.l1tlbtol2tlb_req_retry), 1);
    bus.l2tlbtol1tlb_ack_retry = (stall != 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      if (i == stall - 1) bus.l2tlbtol1tlb_ack_retry = 1'b0;
      chk("ack_held_valid",  32'(bus.l2tlbtol1tlb_ack_valid), 1);
      chk("ack_held_txid",   32'(bus.l2tlbtol1tlb_ack.txid), 32'(tx));
      chk("ack_held_hpaddr", 32'(bus.l2tlbtol1tlb_ack.hpaddr), 32'(hp));
      chk("req_retry_held",  32'(bus.l1tlbtol2tlb_req_retry), 1);
    end
    tick();
    chk("ack_done",       32'(bus.l2tlbtol1tlb_ack_valid), 0);
    chk("req_retry_free", 32'(bus.l1tlbtol2tlb_req_retry), 0);
  endtask

  // Hit or free-slot miss: ack at N+2 and no snoop
  task automatic req_free(input logic [3:0] tx, input logic [31:0] la, input logic [10:0] hp);
    send_req(tx, la);
    tick();
    chk("no_snoop", 32'(bus.l2tlbtol1tlb_snoop_valid), 0);
    expect_ack(tx, hp, 0);
  endtask

`ifdef L2TLB_RESP_SNOOP_EN
  // Full-table miss: snoop at N+2, optional snoop stall, optional bad sack, good sack 3 cycles later
  task automatic miss_snoop(input logic [10:0] hp, input logic [10:0] vic,
                            input int sstall, input int astall, input bit bad);
    send_req(hp[3:0], {9'h000, hp, 12'h000});
    tick();
    $display("snoop hpaddr=0x%03h expect victim=0x%03h", bus.l2tlbtol1tlb_snoop.hpaddr, vic);
    chk("snoop_valid", 32'(bus.l2tlbtol1tlb_snoop_valid), 1);
    chk("snoop_hp",    32'(bus.l2tlbtol1tlb_snoop.hpaddr), 32'(vic));
    chk("snoop_noack", 32'(bus.l2tlbtol1tlb_ack_valid), 0);
    bus.l2tlbtol1tlb_snoop_retry = (sstall != 0);
    for (int i = 0; i < sstall; i++) begin
      tick();
      if (i == sstall - 1) bus.l2tlbtol1tlb_snoop_retry = 1'b0;
      chk("snoop_held_valid", 32'(bus.l2tlbtol1tlb_snoop_valid), 1);
      chk("snoop_held_hp",    32'(bus.l2tlbtol1tlb_snoop.hpaddr), 32'(vic));
      chk("req_retry_snoop",  32'(bus.l1tlbtol2tlb_req_retry), 1);
    end
    tick();
    chk("snoop_once", 32'(bus.l2tlbtol1tlb_snoop_valid), 0);
    chk("wait_noack", 32'(bus.l2tlbtol1tlb_ack_valid), 0);
    if (bad) begin
      bus.l1tlbtol2tlb_sack.hpaddr = 11'h055;
      bus.l1tlbtol2tlb_sack_valid  = 1'b1;
      chk("bad_sack_retry", 32'(bus.l1tlbtol2tlb_sack_retry), 0);
      tick();
      bus.l1tlbtol2tlb_sack_valid = 1'b0;
      chk("bad_sack_err",   32'(bus.sack_err), 1);
      chk("bad_sack_noack", 32'(bus.l2tlbtol1tlb_ack_valid), 0);
    end else begin
      tick();
    end
    tick();
    chk("pre_sack_noack", 32'(bus.l2tlbtol1tlb_ack_valid), 0);
    bus.l1tlbtol2tlb_sack.hpaddr = vic;
    bus.l1tlbtol2tlb_sack_valid  = 1'b1;
    chk("sack_retry", 32'(bus.l1tlbtol2tlb_sack_retry), 0);
    tick();
    bus.l1tlbtol2tlb_sack_valid = 1'b0;
    expect_ack(hp[3:0], hp, astall);
  endtask
`endif

  initial begin
    reset = 1'b0;
    bus.l1tlbtol2tlb_req_valid   = 1'b0;
    bus.l1tlbtol2tlb_req         = '0;
    bus.l2tlbtol1tlb_ack_retry   = 1'b0;
    bus.l2tlbtol1tlb_snoop_retry = 1'b0;
    bus.l1tlbtol2tlb_sack_valid  = 1'b0;
    bus.l1tlbtol2tlb_sack        = '0;
    tick();
    async_reset_check();
    repeat (3) tick();

    // Basic translation, then the same address again as a hit
    req_free(4'd5, 32'h0040_3000, 11'h403);
    req_free(4'd5, 32'h0040_3000, 11'h403);

    // Start the fill from an empty table
    async_reset_check();
    tick();
    for (int k = 1; k <= 8; k++) begin
      logic [10:0] hp;
      hp = 11'(k);
      req_free(hp[3:0], {9'h1F0, hp, 12'h5A5}, hp);
    end

`ifdef L2TLB_RESP_SNOOP_EN
    miss_snoop(11'h009, 11'h001, 0, 0, 1'b0);
    chk("sack_err_clean1", 32'(bus.sack_err), 0);
    miss_snoop(11'h00A, 11'h002, 3, 4, 1'b0);
    chk("sack_err_clean2", 32'(bus.sack_err), 0);
    miss_snoop(11'h00B, 11'h003, 0, 0, 1'b1);
    chk("sack_err_sticky", 32'(bus.sack_err), 1);
    // Reset while waiting for the sack of victim 0x004
    send_req(4'hC, 32'h0000_C000);
    tick();
    chk("snoop_c_hp", 32'(bus.l2tlbtol1tlb_snoop.hpaddr), 32'h004);
    tick();
    chk("in_wait_sack", 32'(bus.l1tlbtol2tlb_req_retry), 1);
    async_reset_check();
    tick();
    req_free(4'd1, 32'h0000_1000, 11'h001);
`else
    req_free(4'd9, 32'h0000_9000, 11'h009);
    req_free(4'hA, 32'h0000_A000, 11'h00A);
`endif

    // A sack with no snoop outstanding is flagged and stays flagged
    chk("idle_sack_err0", 32'(bus.sack_err), 0);
    bus.l1tlbtol2tlb_sack.hpaddr = 11'h123;
    bus.l1tlbtol2tlb_sack_valid  = 1'b1;
    chk("idle_sack_retry", 32'(bus.l1tlbtol2tlb_sack_retry), 0);
    tick();
    bus.l1tlbtol2tlb_sack_valid = 1'b0;
    chk("idle_sack_err1", 32'(bus.sack_err), 1);
    tick();
    chk("idle_sack_err_sticky", 32'(bus.sack_err), 1);

    // Ack held for 4 cycles while the next request waits
    send_req(4'd7, 32'h0040_4000);
    tick();
    bus.l1tlbtol2tlb_req.txid  = 4'd8;
    bus.l1tlbtol2tlb_req.laddr = 32'h0040_5000;
    bus.l1tlbtol2tlb_req_valid = 1'b1;
    expect_ack(4'd7, 11'h404, 4);
    tick();
    bus.l1tlbtol2tlb_req_valid = 1'b0;
    chk("queued_req_taken", 32'(bus.l1tlbtol2tlb_req_retry), 1);
    chk("queued_no_ack",    32'(bus.l2tlbtol1tlb_ack_valid), 0);
    tick();
    expect_ack(4'd8, 11'h405, 0);

    // Reset while an ack is pending; sack_err is set going in
    send_req(4'd9, 32'h0040_6000);
    tick();
    chk("pre_rst_ack", 32'(bus.l2tlbtol1tlb_ack_valid), 1);
    chk("pre_rst_err", 32'(bus.sack_err), 1);
    async_reset_check();
    tick();
    req_free(4'd1, 32'h0000_1000, 11'h001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
